// File: rtl/icon_anim_renderer.sv
// Animated tick / cross glyph renderer for a 96x64 OLED pixel stream.
// It draws the glyph left to right over successive frames, holds it, then pulses done.
// The output colour is registered and is valid one cycle after pixel_index.
// Optional feature macro ICON_ANIM_BLINK_EN: when defined, the glyph blinks during the hold phase.
module icon_anim_renderer #(
  parameter int          WIDTH        = 96,
  parameter int          HEIGHT       = 64,
  parameter int          PIX_W        = 13,
  parameter int          X_OFF        = 0,
  parameter int          Y_OFF        = 0,
  parameter int          HALF_W       = 1,
  parameter int          STEP_PX      = 4,
  parameter int          HOLD_FRAMES  = 30,
  parameter logic [15:0] TICK_COLOR   = 16'h07E0,
  parameter logic [15:0] CROSS_COLOR  = 16'hF800,
  parameter logic [15:0] BG_COLOR     = 16'h0000,
  parameter int          BLINK_FRAMES = 8
) (
  input  logic             my_clk_25m,
  input  logic             reset,
  input  logic [PIX_W-1:0] pixel_index,
  input  logic             start,
  input  logic             glyph_sel,
  input  logic             flip,
  output logic [15:0]      oled_color,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StDraw, StHold} state_e;

  localparam logic [PIX_W-1:0] LP_W      = PIX_W'(WIDTH);
  localparam logic [PIX_W-1:0] LP_W1     = PIX_W'(WIDTH - 1);
  localparam logic [PIX_W-1:0] LP_H1     = PIX_W'(HEIGHT - 1);
  localparam logic [15:0]      HOLD_LAST = 16'(HOLD_FRAMES - 1);
  localparam logic [6:0]       TICK_SPAN  = 7'd57;
  localparam logic [6:0]       CROSS_SPAN = 7'd45;

  // Reject configurations the datapath cannot represent.
  if (HOLD_FRAMES < 1 || BLINK_FRAMES < 1 || (2 ** PIX_W) < WIDTH * HEIGHT) begin : g_param_chk
    $error("icon_anim_renderer: invalid parameter set");
  end

  state_e           r_state;
  logic [PIX_W-1:0] r_prev_idx;
  logic             r_flip;
  logic [6:0]       r_prog;
  logic [15:0]      r_hold_cnt;
  logic             r_sel;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_color;

  logic             w_tick;
  logic [PIX_W-1:0] w_xr, w_yr, w_x, w_y;
  logic signed [15:0] w_lx, w_ly, w_da, w_db, w_dc, w_dd, w_lim;
  logic             w_in_box, w_tick_hit, w_cross_hit, w_vis, w_blink_ok;
  logic [6:0]       w_span;
  logic [7:0]       w_sum;
  logic             w_enter_hold;
  logic [15:0]      w_color;

  // A new frame starts when the index wraps back to zero.
  assign w_tick = (r_prev_idx != '0) && (pixel_index == '0);

  assign w_xr = pixel_index % LP_W;
  assign w_yr = pixel_index / LP_W;
  assign w_x  = r_flip ? (LP_W1 - w_xr) : w_xr;
  assign w_y  = r_flip ? (LP_H1 - w_yr) : w_yr;
  assign w_lx = 16'(int'(w_x) - X_OFF);
  assign w_ly = 16'(int'(w_y) - Y_OFF);

  // Glyph box is always 96x64; indices past the panel are background.
  assign w_in_box = (w_lx >= 0) && (w_lx < 96) && (w_ly >= 0) && (w_ly < 64) &&
                    (int'(pixel_index) < WIDTH * HEIGHT);

  assign w_da = w_ly - w_lx - 16'sd12;
  assign w_db = w_lx + w_ly - 16'sd92;
  assign w_dc = w_ly - w_lx + 16'sd16;
  assign w_dd = w_lx + w_ly - 16'sd80;

  assign w_tick_hit  = ((w_lx >= 20) && (w_lx <= 40) && (w_da >= -HALF_W) && (w_da <= HALF_W)) ||
                       ((w_lx >= 40) && (w_lx <= 76) && (w_db >= -HALF_W) && (w_db <= HALF_W));
  assign w_cross_hit = (w_lx >= 26) && (w_lx <= 70) &&
                       (((w_dc >= -HALF_W) && (w_dc <= HALF_W)) ||
                        ((w_dd >= -HALF_W) && (w_dd <= HALF_W)));

  assign w_lim = $signed({9'b0, r_prog}) + (r_sel ? 16'sd26 : 16'sd20);
  assign w_vis = (w_lx < w_lim);

  assign w_span       = r_sel ? CROSS_SPAN : TICK_SPAN;
  assign w_sum        = {1'b0, r_prog} + 8'(STEP_PX);
  assign w_enter_hold = (r_state == StDraw) && w_tick && (w_sum >= {1'b0, w_span});

`ifdef ICON_ANIM_BLINK_EN
  logic        r_blink_vis;
  logic [15:0] r_blink_cnt;

  // Blink phase: restarts visible on HOLD entry, toggles every BLINK_FRAMES frame ticks.
  always_ff @(posedge my_clk_25m or posedge reset) begin
    if (reset) begin
      r_blink_vis <= 1'b1;
      r_blink_cnt <= '0;
    end else if (w_enter_hold) begin
      r_blink_vis <= 1'b1;
      r_blink_cnt <= '0;
    end else if (r_state == StHold && w_tick) begin
      if (r_blink_cnt == 16'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_vis <= ~r_blink_vis;
      end else begin
        r_blink_cnt <= r_blink_cnt + 16'd1;
      end
    end
  end

  assign w_blink_ok = (r_state != StHold) || r_blink_vis;
`else
  assign w_blink_ok = 1'b1;
`endif

  // Colour of the current pixel before the output register.
  always_comb begin
    w_color = BG_COLOR;
    if (r_state != StIdle && w_in_box && w_vis && w_blink_ok) begin
      if (!r_sel && w_tick_hit) begin
        w_color = TICK_COLOR;
      end else if (r_sel && w_cross_hit) begin
        w_color = CROSS_COLOR;
      end
    end
  end

  // Sequencer with registered colour, busy and done.
  always_ff @(posedge my_clk_25m or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_prev_idx <= '0;
      r_flip     <= 1'b0;
      r_prog     <= '0;
      r_hold_cnt <= '0;
      r_sel      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_color    <= BG_COLOR;
    end else begin
      r_prev_idx <= pixel_index;
      r_color    <= w_color;
      r_done     <= 1'b0;
      if (w_tick) begin
        r_flip <= flip;
      end
      case (r_state)
        StIdle: begin
          // A start landing in the done cycle is dropped.
          if (start && !r_done) begin
            r_sel   <= glyph_sel;
            r_prog  <= '0;
            r_busy  <= 1'b1;
            r_state <= StDraw;
          end
        end
        StDraw: begin
          if (w_enter_hold) begin
            r_prog     <= w_span;
            r_hold_cnt <= '0;
            r_state    <= StHold;
          end else if (w_tick) begin
            r_prog <= w_sum[6:0];
          end
        end
        StHold: begin
          if (w_tick) begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end else begin
              r_hold_cnt <= r_hold_cnt + 16'd1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign oled_color = r_color;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_icon_anim_renderer.sv
// Self-checking bench for icon_anim_renderer (default build, blink disabled).
// Frames are shortened: a frame tick is produced by driving a nonzero index followed by 0.
module tb_icon_anim_renderer;

  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] BG    = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] pix;
  logic        start, gsel, flip;
  logic [15:0] color;
  logic        busy, done;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  always #20 clk = ~clk;

  icon_anim_renderer dut (
    .my_clk_25m (clk),
    .reset      (rst),
    .pixel_index(pix),
    .start      (start),
    .glyph_sel  (gsel),
    .flip       (flip),
    .oled_color (color),
    .busy       (busy),
    .done       (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one index and queue the colour expected for it one cycle later.
  task automatic send(input logic [12:0] idx, input logic [15:0] exp);
    pix = idx;
    exp_q.push_back(exp);
    step();
  endtask

  task automatic next_frame();
    pix = 13'd6143;
    step();
    pix = 13'd0;
    step();
  endtask

  task automatic pulse_start(input logic sel);
    gsel  = sel;
    pix   = 13'd100;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; gsel = 1'b0; flip = 1'b0; pix = '0;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (color !== BG) begin errors++; $display("FAIL reset_color got=%h exp=%h", color, BG); end
    rst = 1'b0;
    for (int i = 0; i < 6160; i++) begin
      send(13'(i), BG);
      e = exp_q.pop_front();
      checks++;
      if (color !== e) begin errors++; $display("FAIL idle_scan idx=%0d got=%h exp=%h", i, color, e); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_tick_draw();
    logic [12:0] p2i [4] = '{13'd3577, 13'd5032, 13'd3771, 13'd3868};
    logic [15:0] p2e [4] = '{GREEN, BG, GREEN, BG};
    pulse_start(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got=%b exp=1", busy); end
    send(13'd3577, BG);
    e = exp_q.pop_front(); checks++;
    if (color !== e) begin errors++; $display("FAIL draw_p0 idx=3577 got=%h exp=%h", color, e); end
    next_frame();
    next_frame();
    foreach (p2i[k]) begin
      send(p2i[k], p2e[k]);
      e = exp_q.pop_front(); checks++;
      if (color !== e) begin errors++; $display("FAIL draw_p8 idx=%0d got=%h exp=%h", p2i[k], color, e); end
    end
    // Second start while busy must not switch to the cross.
    pulse_start(1'b1);
    send(13'd3577, GREEN);
    e = exp_q.pop_front(); checks++;
    if (color !== e) begin errors++; $display("FAIL start_ignored idx=3577 got=%h exp=%h", color, e); end
    for (int t = 3; t <= 14; t++) begin
      next_frame();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL early_done tick=%0d got=%b exp=0", t, done); end
    end
    send(13'd1612, BG);
    e = exp_q.pop_front(); checks++;
    if (color !== e) begin errors++; $display("FAIL draw_p56_edge idx=1612 got=%h exp=%h", color, e); end
    send(13'd5032, GREEN);
    e = exp_q.pop_front(); checks++;
    if (color !== e) begin errors++; $display("FAIL draw_p56 idx=5032 got=%h exp=%h", color, e); end
    next_frame();
    send(13'd1612, GREEN);
    e = exp_q.pop_front(); checks++;
    if (color !== e) begin errors++; $display("FAIL full_tick_edge idx=1612 got=%h exp=%h", color, e); end
    for (int t = 16; t <= 45; t++) begin
      next_frame();
      checks++;
      if (done !== (t == 45)) begin errors++; $display("FAIL done_timing tick=%0d got=%b exp=%b", t, done, (t == 45)); end
      checks++;
      if (busy !== (t != 45)) begin errors++; $display("FAIL busy_timing tick=%0d got=%b exp=%b", t, busy, (t != 45)); end
    end
    // Start presented in the done cycle must be dropped.
    gsel = 1'b1;
    start = 1'b1;
    send(13'd5032, BG);
    start = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (color !== e) begin errors++; $display("FAIL after_done idx=5032 got=%h exp=%h", color, e); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_on_done busy got=%b exp=0", busy); end
  endtask

  task automatic test_cross_hold();
    logic [12:0] hi [3] = '{13'd3120, 13'd5032, 13'd5254};
    logic [15:0] he [3] = '{RED, BG, RED};
    pulse_start(1'b1);
    gsel = 1'b0;
    repeat (11) next_frame();
    send(13'd5254, BG);
    e = exp_q.pop_front(); checks++;
    if (color !== e) begin errors++; $display("FAIL cross_p44_edge idx=5254 got=%h exp=%h", color, e); end
    next_frame();
    foreach (hi[k]) begin
      send(hi[k], he[k]);
      e = exp_q.pop_front(); checks++;
      if (color !== e) begin errors++; $display("FAIL cross_full idx=%0d got=%h exp=%h", hi[k], color, e); end
    end
    for (int t = 13; t <= 42; t++) begin
      next_frame();
      checks++;
      if (done !== (t == 42)) begin errors++; $display("FAIL cross_done tick=%0d got=%b exp=%b", t, done, (t == 42)); end
    end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL cross_done_width got=%b exp=0", done); end
  endtask

  task automatic test_flip();
    logic [12:0] fi [2] = '{13'd5032, 13'd1111};
    logic [15:0] fe0 [2] = '{GREEN, BG};
    logic [15:0] fe1 [2] = '{BG, GREEN};
    pulse_start(1'b0);
    repeat (15) next_frame();
    flip = 1'b1;
    foreach (fi[k]) begin
      send(fi[k], fe0[k]);
      e = exp_q.pop_front(); checks++;
      if (color !== e) begin errors++; $display("FAIL flip_midframe idx=%0d got=%h exp=%h", fi[k], color, e); end
    end
    next_frame();
    flip = 1'b0;
    foreach (fi[k]) begin
      send(fi[k], fe1[k]);
      e = exp_q.pop_front(); checks++;
      if (color !== e) begin errors++; $display("FAIL flip_latched idx=%0d got=%h exp=%h", fi[k], color, e); end
    end
  endtask

  task automatic test_reset_hold();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy got=%b exp=1", busy); end
    pix = 13'd1111;
    step();
    rst = 1'b1;
    #1;
    checks++; if (color !== BG) begin errors++; $display("FAIL async_rst_color got=%h exp=%h", color, BG); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got=%b exp=0", busy); end
    step();
    rst = 1'b0;
    for (int t = 0; t < 35; t++) begin
      next_frame();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_no_done tick=%0d got=%b exp=0", t, done); end
    end
    send(13'd5032, BG);
    e = exp_q.pop_front(); checks++;
    if (color !== e) begin errors++; $display("FAIL rst_idle idx=5032 got=%h exp=%h", color, e); end
  endtask

  initial begin
    test_reset();
    test_tick_draw();
    test_cross_hold();
    test_flip();
    test_reset_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
